// File: rtl/squeeze_counter.sv
// Squeeze-phase sequencer for the SHAKE core: walks the rate lanes, streams w-bit
// output words on a valid/ready port, and requests a permutation when the rate runs out.
module squeeze_counter #(
    parameter int WIDTH = 32,
    parameter int w     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     out_len,
    input  logic [10:0]          block_size,
    output logic [4:0]           lane_idx,
    input  logic [w-1:0]         state_word,
    output logic                 perm_start,
    input  logic                 perm_done,
    output logic [w-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_last,
    output logic [$clog2(w)-1:0] dout_remainder,
    output logic                 busy,
    output logic                 done
);

    localparam int LW = $clog2(w);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT      = 2'd1,
        PERM_WAIT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [4:0]       lane_idx_q, lane_idx_d;
    logic [4:0]       rate_words_q, rate_words_d;
    logic             perm_start_q, perm_start_d;
    logic             done_q, done_d;

    logic             last_word;
    logic             handshake;

    assign last_word = (remaining_q <= WIDTH'(w));
    assign handshake = (state_q == EMIT) && dout_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            lane_idx_q   <= '0;
            rate_words_q <= '0;
            perm_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            lane_idx_q   <= lane_idx_d;
            rate_words_q <= rate_words_d;
            perm_start_q <= perm_start_d;
            done_q       <= done_d;
        end
    end

    // Next-state and counter logic
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_d      = state_q;
        remaining_d  = remaining_q;
        lane_idx_d   = lane_idx_q;
        rate_words_d = rate_words_q;
        perm_start_d = 1'b0;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (out_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d      = EMIT;
                        remaining_d  = out_len;
                        lane_idx_d   = '0;
                        rate_words_d = 5'(block_size / 11'(w));
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    // Last-word test comes first, so the subtraction below cannot underflow.
                    if (last_word) begin
                        remaining_d = '0;
                        state_d     = IDLE;
                        done_d      = 1'b1;
                    end else begin
                        remaining_d = remaining_q - WIDTH'(w);
                        if (lane_idx_q == rate_words_q - 5'd1) begin
                            lane_idx_d   = '0;
                            perm_start_d = 1'b1;
                            state_d      = PERM_WAIT;
                        end else begin
                            lane_idx_d = lane_idx_q + 5'd1;
                        end
                    end
                end
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        dout_valid     = (state_q == EMIT);
        dout_last      = dout_valid && last_word;
        dout_remainder = dout_last ? remaining_q[LW-1:0] : '0;
        dout           = '0;
        if (dout_valid) begin
            // A final word shorter than w keeps only its low remaining bits.
            if (dout_last && (remaining_q < WIDTH'(w))) begin
                dout = state_word & ~({w{1'b1}} << remaining_q[LW-1:0]);
            end else begin
                dout = state_word;
            end
        end
        lane_idx   = lane_idx_q;
        perm_start = perm_start_q;
        done       = done_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_squeeze_counter.sv
// Directed bench for squeeze_counter: plays the lane mux and permutation engine,
// and checks every output word, flag and pulse against hand-computed values.
module tb_squeeze_counter;

    localparam int WIDTH = 32;
    localparam int W     = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] out_len;
    logic [10:0]      block_size;
    logic [4:0]       lane_idx;
    logic [W-1:0]     state_word;
    logic             perm_start;
    logic             perm_done;
    logic [W-1:0]     dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;
    logic [5:0]       dout_remainder;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    int blk      = 0;

    squeeze_counter #(.WIDTH(WIDTH), .w(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .out_len        (out_len),
        .block_size     (block_size),
        .lane_idx       (lane_idx),
        .state_word     (state_word),
        .perm_start     (perm_start),
        .perm_done      (perm_done),
        .dout           (dout),
        .dout_valid     (dout_valid),
        .dout_ready     (dout_ready),
        .dout_last      (dout_last),
        .dout_remainder (dout_remainder),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Lane contents differ per lane and per permuted block.
    function automatic logic [63:0] lane_word(int b, int l);
        logic [63:0] x;
        x = 64'h9E37_79B9_7F4A_7C15 * 64'(l + 1);
        x = x ^ (64'(b) << 40);
        return x ^ 64'hFEDC_BA98_7654_3210;
    endfunction

    assign state_word = lane_word(blk, int'(lane_idx));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_squeeze(input int len, input int bs);
        start      = 1'b1;
        out_len    = WIDTH'(len);
        block_size = 11'(bs);
        blk        = 0;
        step();
        start = 1'b0;
    endtask

    // Checks the word on the port now, then advances one clock.
    task automatic expect_word(input string tag, input int lane, input bit last, input int rem);
        logic [63:0] exp;
        exp = lane_word(blk, lane);
        if (rem != 0) exp = exp & ((64'h1 << rem) - 64'h1);
        check({tag, " valid"}, 64'(dout_valid), 64'd1);
        check({tag, " lane"}, 64'(lane_idx), 64'(lane));
        check({tag, " last"}, 64'(dout_last), 64'(last));
        check({tag, " rem"}, 64'(dout_remainder), 64'(rem));
        check({tag, " dout"}, dout, exp);
        check({tag, " perm_start"}, 64'(perm_start), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        step();
    endtask

    task automatic expect_done(input string tag);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " valid"}, 64'(dout_valid), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        step();
        check({tag, " done once"}, 64'(done), 64'd0);
    endtask

    task automatic expect_idle_zero(input string tag);
        check({tag, " valid"}, 64'(dout_valid), 64'd0);
        check({tag, " lane"}, 64'(lane_idx), 64'd0);
        check({tag, " perm_start"}, 64'(perm_start), 64'd0);
        check({tag, " done"}, 64'(done), 64'd0);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " dout"}, dout, 64'd0);
        check({tag, " last"}, 64'(dout_last), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] lfsr;
        int          hs;
        int          cyc;

        rst        = 1'b1;
        start      = 1'b0;
        out_len    = '0;
        block_size = '0;
        perm_done  = 1'b0;
        dout_ready = 1'b0;
        repeat (3) step();
        expect_idle_zero("reset");
        rst = 1'b0;
        step();

        // 1: four full words within one block, no permutation
        dout_ready = 1'b1;
        start_squeeze(256, 1344);
        for (int i = 0; i < 4; i++) expect_word("t1 word", i, (i == 3), 0);
        expect_done("t1");

        // 2: partial final word of 36 bits
        start_squeeze(100, 1344);
        expect_word("t2 w0", 0, 1'b0, 0);
        expect_word("t2 w1", 1, 1'b1, 36);
        expect_done("t2");

        // 3: 21 lanes, permutation, one more word
        start_squeeze(1408, 1344);
        for (int i = 0; i < 21; i++) expect_word("t3 word", i, 1'b0, 0);
        check("t3 perm_start", 64'(perm_start), 64'd1);
        check("t3 valid drop", 64'(dout_valid), 64'd0);
        check("t3 busy", 64'(busy), 64'd1);
        step();
        for (int i = 0; i < 23; i++) begin
            check("t3 perm_start once", 64'(perm_start), 64'd0);
            check("t3 wait valid", 64'(dout_valid), 64'd0);
            step();
        end
        blk       = 1;
        perm_done = 1'b1;
        step();
        perm_done = 1'b0;
        expect_word("t3 w21", 0, 1'b1, 0);
        expect_done("t3");

        // 3b: final word on the last rate lane requests no permutation
        start_squeeze(128, 128);
        expect_word("t3b w0", 0, 1'b0, 0);
        expect_word("t3b w1", 1, 1'b1, 0);
        check("t3b no perm", 64'(perm_start), 64'd0);
        expect_done("t3b");

        // 4: ten words under pseudo-random backpressure
        lfsr = 16'hACE1;
        hs   = 0;
        cyc  = 0;
        dout_ready = 1'b0;
        start_squeeze(640, 1344);
        while (hs < 10 && cyc < 300) begin
            lfsr       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            dout_ready = lfsr[0];
            check("t4 valid", 64'(dout_valid), 64'd1);
            check("t4 lane", 64'(lane_idx), 64'(hs));
            check("t4 dout", dout, lane_word(0, hs));
            check("t4 last", 64'(dout_last), 64'(hs == 9));
            if (dout_ready) hs++;
            step();
            cyc++;
        end
        check("t4 handshakes", 64'(hs), 64'd10);
        dout_ready = 1'b1;
        expect_done("t4");

        // 5: zero length, then start ignored while busy
        start_squeeze(0, 1344);
        expect_done("t5 zero");
        start_squeeze(192, 1344);
        expect_word("t5 w0", 0, 1'b0, 0);
        start   = 1'b1;
        out_len = WIDTH'(640);
        expect_word("t5 w1", 1, 1'b0, 0);
        start = 1'b0;
        expect_word("t5 w2", 2, 1'b1, 0);
        expect_done("t5");

        // 6: reset during PERM_WAIT, then a fresh one-word squeeze
        start_squeeze(640, 128);
        expect_word("t6 w0", 0, 1'b0, 0);
        expect_word("t6 w1", 1, 1'b0, 0);
        check("t6 perm_start", 64'(perm_start), 64'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_idle_zero("t6 after rst");
        step();
        check("t6 no done", 64'(done), 64'd0);
        start_squeeze(64, 1344);
        expect_word("t6 w", 0, 1'b1, 0);
        expect_done("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
